// File: rtl/ch1_sweep_freq.sv
// Square channel 1 frequency back end: CPU frequency register, sweep shadow
// shift with add/subtract update and overflow flag, plus the duty-step timer.
module ch1_sweep_freq #(
  parameter int FREQ_W = 11
) (
  input  logic              ajer_2mhz,
  input  logic              apu_reset,
  input  logic [7:0]        d,
  input  logic              apu_wr,
  input  logic              ff13,
  input  logic              ff14,
  input  logic              ch1_restart,
  input  logic              ch1_ld_shift,
  input  logic              ch1_shift_clk,
  input  logic              ch1_freq_upd,
  input  logic              nff10_d3,
  input  logic              freq_tick,
  output logic [FREQ_W-1:0] freq,
  output logic              ch1_duty_clk,
  output logic              ch1_sweep_ovf
);

  logic [FREQ_W-1:0] r_freq;
  logic [FREQ_W-1:0] r_shadow;
  logic [FREQ_W-1:0] r_timer;
  logic              r_duty_clk;
  logic              r_sweep_ovf;

  logic [FREQ_W:0]   w_sum;
  logic              w_add_ovf;
  logic              w_cpu_wr;
  logic              w_timer_max;
  logic [FREQ_W-1:0] w_sweep_freq;

  assign w_sum       = {1'b0, r_freq} + {1'b0, r_shadow};
  assign w_add_ovf   = w_sum[FREQ_W];
  assign w_cpu_wr    = apu_wr && (ff13 || ff14);
  assign w_timer_max = &r_timer;

  // Overflowing add and borrowing subtract both leave the frequency untouched.
  always_comb begin
    w_sweep_freq = r_freq;
    if (nff10_d3) begin
      if (!w_add_ovf) begin
        w_sweep_freq = w_sum[FREQ_W-1:0];
      end
    end else if (r_freq >= r_shadow) begin
      w_sweep_freq = r_freq - r_shadow;
    end
  end

  // A CPU write in the same cycle as a sweep update wins; the update is dropped.
  always_ff @(posedge ajer_2mhz or posedge apu_reset) begin
    if (apu_reset) begin
      r_freq <= '0;
    end else if (w_cpu_wr) begin
      if (ff13) begin
        r_freq[7:0] <= d;
      end
      if (ff14) begin
        r_freq[FREQ_W-1:8] <= d[FREQ_W-9:0];
      end
    end else if (ch1_freq_upd) begin
      r_freq <= w_sweep_freq;
    end
  end

  always_ff @(posedge ajer_2mhz or posedge apu_reset) begin
    if (apu_reset) begin
      r_shadow <= '0;
    end else if (ch1_ld_shift) begin
      r_shadow <= r_freq;
    end else if (ch1_shift_clk) begin
      r_shadow <= {1'b0, r_shadow[FREQ_W-1:1]};
    end
  end

  // Set beats restart so a coinciding overflow still reaches channel1.
  always_ff @(posedge ajer_2mhz or posedge apu_reset) begin
    if (apu_reset) begin
      r_sweep_ovf <= 1'b0;
    end else if (ch1_freq_upd && nff10_d3 && w_add_ovf) begin
      r_sweep_ovf <= 1'b1;
    end else if (ch1_restart) begin
      r_sweep_ovf <= 1'b0;
    end
  end

  always_ff @(posedge ajer_2mhz or posedge apu_reset) begin
    if (apu_reset) begin
      r_timer    <= '0;
      r_duty_clk <= 1'b0;
    end else if (ch1_restart) begin
      r_timer    <= r_freq;
      r_duty_clk <= 1'b0;
    end else if (freq_tick) begin
      if (w_timer_max) begin
        r_timer    <= r_freq;
        r_duty_clk <= 1'b1;
      end else begin
        r_timer    <= r_timer + 1'b1;
        r_duty_clk <= 1'b0;
      end
    end else begin
      r_duty_clk <= 1'b0;
    end
  end

  assign freq          = r_freq;
  assign ch1_duty_clk  = r_duty_clk;
  assign ch1_sweep_ovf = r_sweep_ovf;

endmodule

// File: tb/tb_ch1_sweep_freq.sv
// Bench for ch1_sweep_freq: vector table, hand-written timer/sweep sequences,
// and randomized traffic checked against a period-counting reference model.
module tb_ch1_sweep_freq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  d;
  logic        apu_wr, ff13, ff14;
  logic        restart, ld, shc, upd, dir, tick;
  logic [10:0] freq;
  logic        duty, ovf;

  int total = 0;
  int bad   = 0;

  // reference model state: frequency, shadow, ticks left until the next pulse
  int m_freq, m_shadow, m_rem;
  bit m_duty, m_ovf;

  ch1_sweep_freq #(.FREQ_W(11)) dut (
    .ajer_2mhz    (clk),
    .apu_reset    (rst),
    .d            (d),
    .apu_wr       (apu_wr),
    .ff13         (ff13),
    .ff14         (ff14),
    .ch1_restart  (restart),
    .ch1_ld_shift (ld),
    .ch1_shift_clk(shc),
    .ch1_freq_upd (upd),
    .nff10_d3     (dir),
    .freq_tick    (tick),
    .freq         (freq),
    .ch1_duty_clk (duty),
    .ch1_sweep_ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit       wr, f13, f14;
    bit [7:0] dd;
    bit       ld, sh, up, add, rs, tk;
    bit [10:0] e_freq;
    bit       e_duty, e_ovf;
  } vec_t;

  function automatic vec_t v(bit wr, bit f13, bit f14, bit [7:0] dd,
                             bit l, bit s, bit u, bit a, bit r, bit t,
                             bit [10:0] ef, bit ed, bit eo);
    vec_t x;
    x.wr = wr; x.f13 = f13; x.f14 = f14; x.dd = dd;
    x.ld = l; x.sh = s; x.up = u; x.add = a; x.rs = r; x.tk = t;
    x.e_freq = ef; x.e_duty = ed; x.e_ovf = eo;
    return x;
  endfunction

  task automatic chk(string nm, logic [12:0] act, logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_freq = 0; m_shadow = 0; m_rem = 2048; m_duty = 0; m_ovf = 0;
  endtask

  // Applies one clock of the sweep/timer rules to the model using the inputs
  // currently driven (pre-edge register values for every source operand).
  task automatic model_step();
    int f, s, sum;
    f = m_freq; s = m_shadow; sum = f + s;
    if (upd && dir && sum > 2047) m_ovf = 1;
    else if (restart)             m_ovf = 0;
    if (apu_wr && ff13)      m_freq = (f & 'h700) | int'(d);
    else if (apu_wr && ff14) m_freq = (f & 'h0FF) | ((int'(d) & 7) << 8);
    else if (upd) begin
      if (dir) begin
        if (sum <= 2047) m_freq = sum;
      end else if (f >= s) begin
        m_freq = f - s;
      end
    end
    if (ld)       m_shadow = f;
    else if (shc) m_shadow = s / 2;
    if (restart) begin
      m_rem = 2048 - f; m_duty = 0;
    end else if (tick) begin
      m_rem--;
      if (m_rem == 0) begin m_duty = 1; m_rem = 2048 - f; end
      else m_duty = 0;
    end else begin
      m_duty = 0;
    end
  endtask

  task automatic clear_in();
    d = 8'h00; apu_wr = 0; ff13 = 0; ff14 = 0;
    restart = 0; ld = 0; shc = 0; upd = 0; dir = 0; tick = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_freq(input logic [10:0] f);
    apu_wr = 1; ff13 = 1; d = f[7:0];
    cycle();
    ff13 = 0; ff14 = 1; d = {5'b0, f[10:8]};
    cycle();
    clear_in();
  endtask

  vec_t vt[$];

  initial begin
    int      pulses;
    int      sel;
    clear_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_state", {freq, duty, ovf}, 13'h0);

    // --- table-driven sweep vectors (rows run back to back) ---
    vt.push_back(v(1,1,0,8'h00, 0,0,0,0,0,0, 11'h000,0,0));
    vt.push_back(v(1,0,1,8'h04, 0,0,0,0,0,0, 11'h400,0,0));
    vt.push_back(v(0,0,0,8'h00, 1,0,0,0,0,0, 11'h400,0,0));
    vt.push_back(v(0,0,0,8'h00, 0,1,0,0,0,0, 11'h400,0,0));
    vt.push_back(v(0,0,0,8'h00, 0,0,1,1,0,0, 11'h600,0,0));
    vt.push_back(v(0,0,0,8'h00, 1,0,0,0,0,0, 11'h600,0,0));
    vt.push_back(v(0,0,0,8'h00, 0,0,1,1,0,0, 11'h600,0,1));
    vt.push_back(v(0,0,0,8'h00, 0,0,0,0,0,0, 11'h600,0,1));
    vt.push_back(v(0,0,0,8'h00, 0,0,0,0,1,0, 11'h600,0,0));
    vt.push_back(v(1,0,1,8'hFB, 0,0,0,0,0,0, 11'h300,0,0));
    vt.push_back(v(0,0,0,8'h00, 1,0,0,0,0,0, 11'h300,0,0));
    vt.push_back(v(0,0,0,8'h00, 0,1,0,0,0,0, 11'h300,0,0));
    vt.push_back(v(0,0,0,8'h00, 0,1,0,0,0,0, 11'h300,0,0));
    vt.push_back(v(0,0,0,8'h00, 0,0,1,0,0,0, 11'h240,0,0));
    vt.push_back(v(0,0,0,8'h00, 1,1,0,0,0,0, 11'h240,0,0));
    vt.push_back(v(0,0,0,8'h00, 0,0,1,0,0,0, 11'h000,0,0));
    vt.push_back(v(1,0,1,8'h01, 0,0,0,0,0,0, 11'h100,0,0));
    vt.push_back(v(0,0,0,8'h00, 1,0,0,0,0,0, 11'h100,0,0));
    vt.push_back(v(1,1,0,8'h55, 0,0,1,1,0,0, 11'h155,0,0));
    vt.push_back(v(0,0,0,8'h00, 0,0,1,0,0,0, 11'h055,0,0));
    vt.push_back(v(0,0,0,8'h00, 0,0,1,0,0,0, 11'h055,0,0));
    vt.push_back(v(1,0,1,8'h07, 0,0,0,0,0,0, 11'h755,0,0));
    vt.push_back(v(0,0,0,8'h00, 1,0,0,0,0,0, 11'h755,0,0));
    vt.push_back(v(0,0,0,8'h00, 0,0,1,1,1,0, 11'h755,0,1));
    vt.push_back(v(0,0,0,8'h00, 0,0,0,0,1,0, 11'h755,0,0));
    vt.push_back(v(0,0,0,8'h00, 1,0,0,0,0,0, 11'h755,0,0));
    vt.push_back(v(1,1,0,8'hAA, 0,0,1,1,0,0, 11'h7AA,0,1));
    vt.push_back(v(0,0,0,8'h00, 0,0,0,0,1,0, 11'h7AA,0,0));
    foreach (vt[i]) begin
      apu_wr = vt[i].wr; ff13 = vt[i].f13; ff14 = vt[i].f14; d = vt[i].dd;
      ld = vt[i].ld; shc = vt[i].sh; upd = vt[i].up; dir = vt[i].add;
      restart = vt[i].rs; tick = vt[i].tk;
      cycle();
      chk($sformatf("vec%0d", i), {freq, duty, ovf},
          {vt[i].e_freq, vt[i].e_duty, vt[i].e_ovf});
      $display("vec %0d: freq=%h duty=%0b ovf=%0b", i, freq, duty, ovf);
    end
    clear_in();

    // --- 0x700: one duty pulse every 256 ticks ---
    do_reset();
    set_freq(11'h700);
    restart = 1; cycle(); restart = 0;
    tick = 1;
    pulses = 0;
    for (int i = 1; i <= 512; i++) begin
      cycle();
      if (duty) pulses++;
      chk($sformatf("period256_t%0d", i), 13'(duty), 13'(i == 256 || i == 512));
    end
    tick = 0;
    $display("seq period256: %0d pulses in 512 ticks", pulses);

    // --- CPU write mid-period only matters at the next reload ---
    do_reset();
    set_freq(11'h700);
    restart = 1; cycle(); restart = 0;
    for (int i = 1; i <= 272; i++) begin
      tick = 1;
      if (i == 100) begin apu_wr = 1; ff13 = 1; d = 8'hF0; end
      else begin apu_wr = 0; ff13 = 0; d = 8'h00; end
      cycle();
      chk($sformatf("midwrite_t%0d", i), 13'(duty), 13'(i == 256 || i == 272));
    end
    clear_in();
    $display("seq midwrite: freq=%h", freq);

    // --- freq=2047: a pulse on every tick ---
    set_freq(11'h7FF);
    restart = 1; cycle(); restart = 0;
    tick = 1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      chk($sformatf("max_freq_t%0d", i), 13'(duty), 13'h1);
    end
    tick = 0; cycle();
    chk("max_freq_idle", 13'(duty), 13'h0);
    $display("seq max_freq done");

    // --- reset mid-period: first pulse after 2048 ticks ---
    set_freq(11'h7F0);
    restart = 1; cycle(); restart = 0;
    tick = 1; repeat (5) cycle();
    do_reset();
    tick = 1;
    for (int i = 1; i <= 2048; i++) begin
      cycle();
      chk($sformatf("post_reset_t%0d", i), 13'(duty), 13'(i == 2048));
    end
    tick = 0;
    $display("seq post_reset done");

    // --- shadow shifts to zero after 11 shifts ---
    do_reset();
    set_freq(11'h7FF);
    ld = 1; cycle(); ld = 0;
    shc = 1; repeat (10) cycle(); shc = 0;
    upd = 1; dir = 1; cycle(); upd = 0;
    chk("shift10_add", {freq, duty, ovf}, {11'h7FF, 1'b0, 1'b1});
    restart = 1; cycle(); restart = 0;
    ld = 1; cycle(); ld = 0;
    shc = 1; repeat (11) cycle(); shc = 0;
    upd = 1; dir = 1; cycle(); upd = 0;
    chk("shift11_add", {freq, duty, ovf}, {11'h7FF, 1'b0, 1'b0});
    shc = 1; cycle(); shc = 0;
    upd = 1; dir = 0; cycle(); upd = 0;
    chk("shift12_sub", {freq, duty, ovf}, {11'h7FF, 1'b0, 1'b0});
    $display("seq shadow_zero done");

    // --- asynchronous reset clears outputs before the next edge ---
    restart = 1; cycle(); restart = 0;
    ld = 1; cycle(); ld = 0;
    upd = 1; dir = 1; cycle(); upd = 0;
    chk("pre_async_ovf", 13'(ovf), 13'h1);
    tick = 1; cycle(); tick = 0;
    chk("pre_async_duty", {freq, duty, ovf}, {11'h7FF, 1'b1, 1'b1});
    #1 rst = 1'b1;
    #1;
    chk("async_reset", {freq, duty, ovf}, 13'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    $display("seq async_reset done");

    // --- randomized traffic against the reference model ---
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      sel     = int'($urandom_range(0, 2));
      apu_wr  = ($urandom_range(0, 3) == 0);
      ff13    = (sel == 1);
      ff14    = (sel == 2);
      d       = 8'($urandom);
      ld      = ($urandom_range(0, 7) == 0);
      shc     = ($urandom_range(0, 3) == 0);
      upd     = ($urandom_range(0, 7) == 0);
      dir     = 1'($urandom);
      restart = ($urandom_range(0, 31) == 0);
      tick    = ($urandom_range(0, 3) != 0);
      cycle();
      chk($sformatf("rand%0d", i), {freq, duty, ovf}, {11'(m_freq), m_duty, m_ovf});
    end
    clear_in();
    $display("seq random: 3000 cycles");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
